mask_vect_pipe: RTL



---
 rtl/mask_vect_pipe.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mask_vect_pipe.sv
// mask_vect_pipe: two-stage valid/ready segment-vector masking stage
// with masked-segment count and saturating invalid-beat counter.
module mask_vect_pipe #(
    parameter int         KWID       = 104,
    parameter int         SEGWID     = 10,
    parameter int         NSEG       = KWID / 8,
    parameter int         VTWID      = SEGWID * NSEG,
    parameter logic [1:0] STAT_VALID = 2'b01,
    parameter logic [1:0] MASK_STAT  = 2'b11,
    parameter int         CNTWID     = 16,
    parameter int         CW         = $clog2(NSEG + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_Valid,
    output logic              o_Ready,
    input  logic [SEGWID-1:0] i_Segment,
    input  logic [VTWID-1:0]  i_Segment_Vector,
    input  logic [NSEG-1:0]   i_Mask_Data,
    input  logic [1:0]        i_Mode,
    output logic              o_Valid,
    input  logic              i_Ready,
    output logic [VTWID-1:0]  o_Mask_Vect,
    output logic [CW-1:0]     o_Masked_Cnt,
    output logic              o_All_Masked,
    input  logic              i_Stat_Clr,
    output logic [CNTWID-1:0] o_Invalid_Cnt
);

    logic              r_s1_v;
    logic [VTWID-1:0]  r_s1_vec;
    logic [NSEG-1:0]   r_s1_mask;
    logic [1:0]        r_s1_mode;
    logic              r_s1_inv;

    logic              r_o_v;
    logic [VTWID-1:0]  r_o_vec;
    logic [CW-1:0]     r_o_cnt;
    logic              r_o_all;
    logic [CNTWID-1:0] r_inv_cnt;

    logic              w_s1_adv;
    logic              w_accept;
    logic              w_in_inv;
    logic [NSEG-1:0]   w_em;
    logic [VTWID-1:0]  w_vec;
    logic [CW-1:0]     w_cnt;
    logic              w_all;
    logic              w_unused_id;

    // Only the status field of the selector segment matters.
    assign w_unused_id = ^i_Segment[SEGWID-3:0];

    assign w_s1_adv = r_s1_v && (!r_o_v || i_Ready);
    assign o_Ready  = !r_s1_v || w_s1_adv;
    assign w_accept = i_Valid && o_Ready;
    assign w_in_inv = (i_Segment[SEGWID-1:SEGWID-2] != STAT_VALID);

    assign o_Valid       = r_o_v;
    assign o_Mask_Vect   = r_o_vec;
    assign o_Masked_Cnt  = r_o_cnt;
    assign o_All_Masked  = r_o_all;
    assign o_Invalid_Cnt = r_inv_cnt;

    // Stage 1: capture an accepted beat, hold it while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_v    <= 1'b0;
            r_s1_vec  <= '0;
            r_s1_mask <= '0;
            r_s1_mode <= '0;
            r_s1_inv  <= 1'b0;
        end else if (w_accept) begin
            r_s1_v    <= 1'b1;
            r_s1_vec  <= i_Segment_Vector;
            r_s1_mask <= i_Mask_Data;
            r_s1_mode <= i_Mode;
            r_s1_inv  <= w_in_inv;
        end else if (w_s1_adv) begin
            r_s1_v    <= 1'b0;
        end
    end

    // Effective mask: an invalid selector masks everything.
    always_comb begin
        w_em = '0;
        if (r_s1_inv) begin
            w_em = '1;
        end else begin
            unique case (r_s1_mode)
                2'b00:   w_em = r_s1_mask;
                2'b01:   w_em = ~r_s1_mask;
                2'b10:   w_em = '0;
                default: w_em = '1;
            endcase
        end
    end

    // Apply the mask to status fields and count applied mask bits.
    always_comb begin
        w_vec = r_s1_vec;
        w_cnt = '0;
        for (int k = 0; k < NSEG; k++) begin
            if (w_em[k]) begin
                w_vec[k*SEGWID + SEGWID-2 +: 2] = MASK_STAT;
            end
            w_cnt = w_cnt + CW'(w_em[k]);
        end
        w_all = (w_cnt == CW'(NSEG));
    end

    // Stage 2: output register, held while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_o_v   <= 1'b0;
            r_o_vec <= '0;
            r_o_cnt <= '0;
            r_o_all <= 1'b0;
        end else if (w_s1_adv) begin
            r_o_v   <= 1'b1;
            r_o_vec <= w_vec;
            r_o_cnt <= w_cnt;
            r_o_all <= w_all;
        end else if (i_Ready) begin
            r_o_v   <= 1'b0;
        end
    end

    // Saturating count of accepted invalid beats; clear has priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inv_cnt <= '0;
        end else if (i_Stat_Clr) begin
            r_inv_cnt <= '0;
        end else if (w_accept && w_in_inv && (r_inv_cnt != {CNTWID{1'b1}})) begin
            r_inv_cnt <= r_inv_cnt + 1'b1;
        end
    end

endmodule
